// File: rtl/hash_mem_responder.sv
// Memory-side responder for the hash engines' shared memory port: registered
// reads, stored writes, preload/debug ports and result-window completion tracking.
module hash_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [15:0] BASE        = 16'h0000,
  parameter int unsigned NUM_RESULTS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        arm,
  input  logic [15:0] result_addr,
  input  logic [15:0] dbg_addr,
  output logic [31:0] dbg_data,
  output logic        results_ready,
  output logic        err_oob,
  output logic [15:0] err_addr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NR = NUM_RESULTS;
  localparam int unsigned SW = (NR > 1) ? $clog2(NR) : 1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [15:0]   res_base;
  logic [15:0]   res_base_next;
  logic [NR-1:0] mask;
  logic [NR-1:0] mask_next;

  logic [31:0]   storage [DEPTH];

  logic [15:0]   m_off;
  logic [15:0]   l_off;
  logic [15:0]   d_off;
  logic [15:0]   slot_off;
  logic          m_in;
  logic          l_in;
  logic          d_in;
  logic          m_wr;
  logic          l_wr;
  logic          slot_hit;

  // Address decode: 16-bit wrapping offset from BASE, range-checked against DEPTH.
  always_comb begin
    m_off    = mem_addr - BASE;
    l_off    = load_addr - BASE;
    d_off    = dbg_addr - BASE;
    slot_off = mem_addr - res_base;
    m_in     = ({16'h0, m_off} < DEPTH);
    l_in     = ({16'h0, l_off} < DEPTH);
    d_in     = ({16'h0, d_off} < DEPTH);
    m_wr     = mem_we && m_in && !reset;
    l_wr     = load_en && l_in && (state == LOAD) && !reset;
    slot_hit = m_wr && (state == SERVE) && ({16'h0, slot_off} < NR);
  end

  // State register and result-tracking mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= LOAD;
      mask          <= '0;
      res_base      <= 16'h0000;
      results_ready <= 1'b0;
    end else begin
      state         <= state_next;
      mask          <= mask_next;
      res_base      <= res_base_next;
      results_ready <= (state_next == DONE);
    end
  end

  // Next-state logic; completion is judged on the mask including this cycle's write.
  always_comb begin
    state_next    = state;
    mask_next     = mask;
    res_base_next = res_base;
    case (state)
      LOAD: begin
        if (arm) begin
          state_next    = SERVE;
          res_base_next = result_addr;
        end
      end
      SERVE: begin
        if (slot_hit) begin
          mask_next[SW'(slot_off)] = 1'b1;
        end
        if (&mask_next) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // Storage is never cleared; master write is ordered last so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (l_wr) begin
      storage[AW'(l_off)] <= load_data;
    end
    if (m_wr) begin
      storage[AW'(m_off)] <= mem_write_data;
    end
  end

  // Registered read ports and sticky out-of-range capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_data <= 32'h0;
      dbg_data      <= 32'h0;
      err_oob       <= 1'b0;
      err_addr      <= 16'h0000;
    end else begin
      if (!mem_we) begin
        mem_read_data <= m_in ? storage[AW'(m_off)] : 32'h0;
      end
      dbg_data <= d_in ? storage[AW'(d_off)] : 32'h0;
      if (!m_in && !err_oob) begin
        err_oob  <= 1'b1;
        err_addr <= mem_addr;
      end
    end
  end

endmodule

// File: tb/tb_hash_mem_responder.sv
// Directed bench for hash_mem_responder: one wide instance at BASE 0 and one
// 1024-word instance at BASE 0xFC00 for the wrapping result window.
module tb_hash_mem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        we, load_en, arm;
  logic [15:0] addr, load_addr, result_addr, dbg_addr;
  logic [31:0] wdata, load_data;
  logic [31:0] rdata, dbg_data;
  logic        ready, err;
  logic [15:0] err_addr;

  logic        w_we, w_load_en, w_arm;
  logic [15:0] w_addr, w_load_addr, w_result_addr, w_dbg_addr;
  logic [31:0] w_wdata, w_load_data;
  logic [31:0] w_rdata, w_dbg_data;
  logic        w_ready, w_err;
  logic [15:0] w_err_addr;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  logic [31:0] exp_slot [16];
  int          order [17] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 3, 2, 1, 0};

  always #5 clk = ~clk;

  hash_mem_responder #(.DEPTH(8192), .BASE(16'h0000), .NUM_RESULTS(16)) u_dut (
    .clk(clk), .reset(reset), .mem_we(we), .mem_addr(addr), .mem_write_data(wdata),
    .mem_read_data(rdata), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .arm(arm), .result_addr(result_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .results_ready(ready), .err_oob(err), .err_addr(err_addr)
  );

  hash_mem_responder #(.DEPTH(1024), .BASE(16'hFC00), .NUM_RESULTS(16)) u_wrap (
    .clk(clk), .reset(reset), .mem_we(w_we), .mem_addr(w_addr), .mem_write_data(w_wdata),
    .mem_read_data(w_rdata), .load_en(w_load_en), .load_addr(w_load_addr),
    .load_data(w_load_data), .arm(w_arm), .result_addr(w_result_addr),
    .dbg_addr(w_dbg_addr), .dbg_data(w_dbg_data), .results_ready(w_ready),
    .err_oob(w_err), .err_addr(w_err_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; load_en = 1'b0; arm = 1'b1;
    addr = 16'h0; wdata = 32'h0; load_addr = 16'h0; load_data = 32'h0;
    result_addr = 16'h1234; dbg_addr = 16'h0;
    w_we = 1'b0; w_load_en = 1'b0; w_arm = 1'b0; w_addr = 16'hFC00; w_wdata = 32'h0;
    w_load_addr = 16'hFC00; w_load_data = 32'h0; w_result_addr = 16'h0; w_dbg_addr = 16'hFC00;
    step();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_dbg", dbg_data, 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_err_addr", 32'(err_addr), 32'h0);
    chk("rst_w_err", 32'(w_err), 32'h0);
    reset = 1'b0; arm = 1'b0;

    // Load and master write to the same index: master wins (also proves arm under reset ignored)
    load_en = 1'b1; load_addr = 16'h0030; load_data = 32'h1;
    we = 1'b1; addr = 16'h0030; wdata = 32'h2;
    step();
    load_addr = 16'h0050; load_data = 32'h1234_5678; we = 1'b0;
    step();
    chk("collide", rdata, 32'h2);
    load_addr = 16'h0040; load_data = 32'hA5A5_A5A5;
    step();
    load_en = 1'b0; addr = 16'h0040;
    step();
    chk("load_then_read", rdata, 32'hA5A5_A5A5);

    for (int i = 0; i < 16; i++) begin
      load_en = 1'b1; load_addr = 16'h1000 + 16'(i); load_data = 32'(i) * 32'h1111_1111;
      step();
    end
    load_en = 1'b0;
    arm = 1'b1; result_addr = 16'h0200;
    step();
    arm = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr = 16'h1000 + 16'(i);
      step();
      chk($sformatf("burst_%0d", i), rdata, 32'(i) * 32'h1111_1111);
    end
    chk("burst_err", 32'(err), 32'h0);

    // Load port is ignored once armed
    load_en = 1'b1; load_addr = 16'h0050; load_data = 32'hDEAD_DEAD;
    step();
    load_en = 1'b0; dbg_addr = 16'h0050;
    step();
    chk("load_ignored", dbg_data, 32'h1234_5678);

    // Result writes in reverse order, slot 3 written twice
    we = 1'b1;
    for (int k = 0; k < 17; k++) begin
      addr = 16'h0200 + 16'(order[k]);
      wdata = 32'hB000_0000 + (32'(k) << 8) + 32'(order[k]);
      exp_slot[order[k]] = wdata;
      step();
      chk($sformatf("ready_w%0d", k), 32'(ready), (k == 16) ? 32'h1 : 32'h0);
    end
    chk("write_hold", rdata, 32'hFFFF_FFFF);
    we = 1'b0; addr = 16'h1001;
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 16'h0200 + 16'(i);
      step();
      chk($sformatf("dbg_slot_%0d", i), dbg_data, exp_slot[i]);
    end
    arm = 1'b1; result_addr = 16'h0300;
    step();
    arm = 1'b0;
    chk("done_arm_ignored", 32'(ready), 32'h1);

    // Write then read same address next cycle
    we = 1'b1; addr = 16'h0010; wdata = 32'hCAFE_BABE;
    step();
    chk("raw_hold", rdata, 32'h1111_1111);
    we = 1'b0;
    step();
    chk("raw_read", rdata, 32'hCAFE_BABE);

    // Wrapping window; 0x0000..0x0007 fall outside the BASE=0xFC00 storage
    w_arm = 1'b1; w_result_addr = 16'hFFF8;
    step();
    w_arm = 1'b0; w_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w_addr = 16'hFFF8 + 16'(i); w_wdata = 32'(i);
      step();
      if (i == 7) chk("wrap_err_pre", 32'(w_err), 32'h0);
    end
    w_we = 1'b0; w_addr = 16'hFC00; w_dbg_addr = 16'hFFFF;
    step();
    chk("wrap_ready", 32'(w_ready), 32'h0);
    chk("wrap_err", 32'(w_err), 32'h1);
    chk("wrap_err_addr", 32'(w_err_addr), 32'h0);
    chk("wrap_dbg", w_dbg_data, 32'h7);

    // Reset from DONE: outputs cleared, storage retained
    reset = 1'b1; addr = 16'h0205;
    step();
    chk("rst2_rdata", rdata, 32'h0);
    chk("rst2_dbg", dbg_data, 32'h0);
    chk("rst2_ready", 32'(ready), 32'h0);
    chk("rst2_err", 32'(err), 32'h0);
    chk("rst2_w_err", 32'(w_err), 32'h0);
    reset = 1'b0;
    step();
    chk("rst2_retain", rdata, exp_slot[5]);
    load_en = 1'b1; load_addr = 16'h0060; load_data = 32'h77;
    step();
    load_en = 1'b0; dbg_addr = 16'h0060;
    step();
    chk("rst2_load_state", dbg_data, 32'h77);

    // Out-of-range master read: zero data, sticky error with first address
    addr = 16'h3000;
    step();
    chk("oob_rdata", rdata, 32'h0);
    chk("oob_err", 32'(err), 32'h1);
    chk("oob_err_addr", 32'(err_addr), 32'h3000);
    addr = 16'h4000;
    step();
    chk("oob_first_only", 32'(err_addr), 32'h3000);
    addr = 16'h0000;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/hash_mem_responder.md
# hash_mem_responder

Memory-side responder for the hash engines' shared memory port. It answers the master's `mem_we`/`mem_addr`/`mem_write_data` requests with one-cycle registered read data, and stores written words. It tracks writes into a configurable result window and flags when every result slot has been written. It sits between the testbench (preload and debug readback) and the hash core (functional master), replacing the behavioural memory in block-level and system benches.

## Interface
- `DEPTH`, 1024: number of 32-bit words stored.
- `BASE`, 16'h0000: master address that maps to word 0.
- `NUM_RESULTS`, 16: result slots tracked; must be 1..32.
- `clk` in 1: single clock; the master's `mem_clk` is tied to this.
- `reset` in 1: synchronous, active-high.
- `mem_we` in 1: write strobe from master.
- `mem_addr` in 16: word address from master.
- `mem_write_data` in 32: write data from master.
- `mem_read_data` out 32: registered read data to master.
- `load_en` in 1: preload write strobe, testbench side.
- `load_addr` in 16: preload address, same map as `mem_addr`.
- `load_data` in 32: preload data.
- `arm` in 1: single-cycle pulse; leave LOAD and start result tracking.
- `result_addr` in 16: first result address; sampled on `arm`.
- `dbg_addr` in 16: readback address.
- `dbg_data` out 32: registered readback data.
- `results_ready` out 1: all result slots written.
- `err_oob` out 1: sticky out-of-range access flag.
- `err_addr` out 16: first out-of-range address.

## Operation
- Index = `addr - BASE` (16-bit wrap). The address is in range iff index < `DEPTH`.
- FSM states:
  - LOAD: reset state. `load_en` writes storage. Master port is fully served. No result tracking. `arm` goes to SERVE.
  - SERVE: `load_en` is ignored. Master writes are stored and tracked. When the written mask is all ones, go to DONE.
  - DONE: `results_ready` = 1. Master port is still served. `arm` is ignored. Only `reset` leaves DONE.
- `arm` in LOAD captures `result_addr` into `res_base`. Slot i = address (`res_base` + i) mod 2^16, for i in 0..NUM_RESULTS-1. The window may wrap past 16'hFFFF.
- Tracking uses a `NUM_RESULTS`-bit written mask. A write setting an already-set bit does not advance anything. The order of writes is irrelevant.
- Writes outside the window are stored but not tracked.
- Master read (`mem_we` = 0): `mem_read_data` <= word[index], or 32'h0 if out of range.
- Master write (`mem_we` = 1): store if in range. `mem_read_data` holds its previous value.
- Out of range on the master port (read or write): write dropped, `err_oob` set. `err_addr` is captured only on the first error. Load port and dbg port never raise `err_oob`.
- Simultaneous `load_en` and master write in LOAD to the same index: the master write wins.
- `dbg_data` <= word[dbg index], or 0 if out of range, every cycle. It reflects storage before any same-cycle write.
- Storage contents are not cleared by `reset`.

## Timing
- Reset values, all registered, applied at the first `clk` edge with `reset` high:
  - `mem_read_data` = 0, `dbg_data` = 0.
  - `results_ready` = 0.
  - `err_oob` = 0, `err_addr` = 0.
  - Mask = 0, state = LOAD.
- Read latency is 1 cycle: address presented in cycle n, data valid after edge n+1. Back-to-back reads at one per cycle.
- Read-after-write: a write in cycle n followed by a read of the same address in cycle n+1 returns the new data after edge n+2.
- Load then master read of the same address in the next cycle returns the loaded value.
- `results_ready` rises on the edge that stores the last missing slot write. There is no extra latency.
- `reset` mid-SERVE or in DONE: return to LOAD with mask cleared; storage retained.
- `arm` while `reset` is high is ignored.

## Test plan
- Preload 0x1000..0x100F with i*0x11111111, arm, master reads 0x1000..0x100F back-to-back. Required: each value appears exactly 1 cycle after its address; `err_oob` stays 0.
- Arm with `result_addr`=0x0200. Master writes 16 words to 0x0200..0x020F in reverse order, with slot 3 written twice. Required: `results_ready` stays 0 until the 16th distinct slot; it rises on that write's edge; `dbg_data` then returns each written word.
- Arm with `result_addr`=0xFFF8, `BASE`=0xFC00. Write 0xFFF8..0xFFFF and 0x0000..0x0007. Required: the 0x0000..0x0007 writes are out of range, so `results_ready` stays 0; `err_oob`=1 and `err_addr`=0x0000 (first offender).
- Master write 0xCAFEBABE to 0x0010, then a read of 0x0010 in the next cycle. Required: `mem_read_data` = 0xCAFEBABE one cycle later; during the write cycle it held the prior value.
- Reach DONE, assert `reset` one cycle, then read previously written 0x0205. Required: all outputs at reset values, state LOAD, read returns the stored word.
- In LOAD, drive `load_en` (data 0x1) and a master write (data 0x2) to 0x0030 in the same cycle. Required: a later read returns 0x2.
